// File: rtl/mem_line_arbiter_pkg.sv
// Shared constants and encodings for the cache line-fill arbiter.
package mem_line_arbiter_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_SIZE      = WORD_SIZE * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_line_arbiter_line_beat_buf.sv
// Line buffer: word-indexed load for read assembly, word-indexed select for
// write-back serialisation. Word 0 sits in the most significant slot.
module line_beat_buf #(
  parameter  int WORD_W         = 16,
  parameter  int WORDS_PER_LINE = 4,
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE,
  localparam int IDX_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load_line,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_load_word,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_word,
  output logic [LINE_W-1:0] o_line_next,
  output logic [WORD_W-1:0] o_word
);

  logic [LINE_W-1:0] r_line;

  // o_line_next already contains the word being loaded this cycle, so the
  // owner can capture a complete line on the final beat.
  always_comb begin
    o_line_next = r_line;
    o_word      = '0;
    for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
      if (i_idx == IDX_W'(k)) begin
        o_word = r_line[LINE_W-1-WORD_W*k -: WORD_W];
        if (i_load_word) begin
          o_line_next[LINE_W-1-WORD_W*k -: WORD_W] = i_word;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_line <= '0;
    end else if (i_load_line) begin
      r_line <= i_line;
    end else if (i_load_word) begin
      r_line <= o_line_next;
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Arbitrates I/D cache line requests onto a word-wide memory port, moving
// each line as a burst of sequential word beats.
module mem_line_arbiter #(
  parameter  int WORD_W         = 16,
  parameter  int WORDS_PER_LINE = 4,
  parameter  int ADDR_W         = 16,
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_line,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_line,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  import mem_line_arbiter_pkg::*;

  localparam int                BEAT_W    = $clog2(WORDS_PER_LINE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(WORDS_PER_LINE - 1);

  state_t            r_state, w_state_next;
  grant_t            r_grant, r_last_grant, w_sel;
  logic [BEAT_W-1:0] r_beat;
  logic [ADDR_W-1:0] r_base;
  logic              r_we, r_hold;
  logic              w_start, w_beat_done;
  logic [LINE_W-1:0] r_i_line, r_d_line, w_line_next;
  logic [WORD_W-1:0] w_buf_word;

  assign i_line = r_i_line;
  assign d_line = r_d_line;

  line_beat_buf #(
    .WORD_W        (WORD_W),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load_line(w_start && (w_sel == GNT_D) && d_we),
    .i_line     (d_wdata),
    .i_load_word(w_beat_done && !r_we),
    .i_idx      (r_beat),
    .i_word     (mem_rdata),
    .o_line_next(w_line_next),
    .o_word     (w_buf_word)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // r_hold masks the first IDLE cycle after ACK, while the requester is
  // still dropping its request.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_sel        = r_grant;
    w_beat_done  = 1'b0;
    i_ack        = 1'b0;
    d_ack        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      IDLE: begin
        if (!r_hold && (i_req || d_req)) begin
          w_start      = 1'b1;
          w_state_next = XFER;
          if (i_req && d_req) begin
            w_sel = (r_last_grant == GNT_I) ? GNT_D : GNT_I;
          end else begin
            w_sel = d_req ? GNT_D : GNT_I;
          end
        end
      end
      XFER: begin
        mem_addr  = r_base | ADDR_W'(r_beat);
        mem_read  = !r_we;
        mem_write = r_we;
        mem_wdata = r_we ? w_buf_word : '0;
        if (mem_ready) begin
          w_beat_done = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_state_next = ACK;
          end
        end
      end
      ACK: begin
        i_ack        = (r_grant == GNT_I);
        d_ack        = (r_grant == GNT_D);
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_grant      <= GNT_I;
      r_last_grant <= GNT_I;
      r_beat       <= '0;
      r_base       <= '0;
      r_we         <= 1'b0;
      r_hold       <= 1'b0;
      r_i_line     <= '0;
      r_d_line     <= '0;
    end else begin
      r_hold <= (r_state == ACK);
      if (w_start) begin
        r_grant <= w_sel;
        r_base  <= ((w_sel == GNT_D) ? d_addr : i_addr) & ~BEAT_MASK;
        r_we    <= (w_sel == GNT_D) && d_we;
        r_beat  <= '0;
      end else if (w_beat_done) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
      if (w_beat_done && (r_beat == LAST_BEAT) && !r_we) begin
        if (r_grant == GNT_D) begin
          r_d_line <= w_line_next;
        end else begin
          r_i_line <= w_line_next;
        end
      end
      if (r_state == ACK) begin
        r_last_grant <= r_grant;
      end
    end
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter: expected beats and acks are queued
// when a request is driven and retired as the DUT produces them.
module tb_mem_line_arbiter;

  logic        clk = 1'b0;
  logic        reset_n, i_req, d_req, d_we, mem_ready;
  logic [15:0] i_addr, d_addr, mem_addr, mem_wdata, mem_rdata;
  logic [63:0] d_wdata, i_line, d_line;
  logic        i_ack, d_ack, mem_read, mem_write;

  always #5 clk = ~clk;

  // Memory model: every word reads back as A000 + its address.
  assign mem_rdata = 16'hA000 + mem_addr;

  mem_line_arbiter #(
    .WORD_W        (16),
    .WORDS_PER_LINE(4),
    .ADDR_W        (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_line   (i_line),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_line   (d_line),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
    int          cyc;
  } beat_t;

  typedef struct {
    logic        is_d;
    logic [63:0] line;
    int          cyc;
  } ack_t;

  beat_t       q_beat[$];
  ack_t        q_ack[$];
  int          n_checks = 0, n_pass = 0, cyc = 0, n_ack_seen = 0;
  int          stall_from = 0, stall_to = 0, i_left = 0, d_left = 0;
  logic        i_drop = 1'b0, d_drop = 1'b0;
  logic [63:0] m_i_line = '0, m_d_line = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic monitor();
    beat_t b;
    ack_t  a;
    if (mem_read || mem_write) begin
      if (q_beat.size() == 0) begin
        chk("stray_strobe", {mem_read, mem_write}, 2'b00);
      end else begin
        b = q_beat[0];
        chk("mem_addr", mem_addr, b.addr);
        chk("mem_dir", {mem_write, mem_read}, {b.we, !b.we});
        if (b.we) chk("mem_wdata", mem_wdata, b.data);
        if (mem_ready) begin
          chk("beat_cycle", cyc, b.cyc);
          void'(q_beat.pop_front());
        end
      end
    end
    if (i_ack || d_ack) begin
      n_ack_seen++;
      chk("ack_mem_quiet", {mem_read, mem_write}, 2'b00);
      if (q_ack.size() == 0) begin
        chk("stray_ack", {d_ack, i_ack}, 2'b00);
      end else begin
        a = q_ack.pop_front();
        chk("ack_sel", {d_ack, i_ack}, a.is_d ? 2'b10 : 2'b01);
        chk("ack_cycle", cyc, a.cyc);
        if (a.is_d) chk("d_line", d_line, a.line);
        else        chk("i_line", i_line, a.line);
      end
      if (i_ack) begin
        i_left--;
        if (i_left <= 0) i_drop = 1'b1;
      end
      if (d_ack) begin
        d_left--;
        if (d_left <= 0) d_drop = 1'b1;
      end
    end
  endtask

  // One clock: update inputs just after the edge, check outputs mid-cycle.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    if (i_drop) begin i_req = 1'b0; i_drop = 1'b0; end
    if (d_drop) begin d_req = 1'b0; d_drop = 1'b0; end
    mem_ready = !((cyc >= stall_from) && (cyc < stall_to));
    @(negedge clk);
    monitor();
  endtask

  task automatic push_xfer(input logic is_d, input logic we, input logic [15:0] addr,
                           input logic [63:0] wdata, input int k,
                           input int stall_beat, input int stall_len);
    logic [15:0] base;
    logic [63:0] line;
    beat_t       b;
    ack_t        a;
    base = addr & 16'hFFFC;
    line = '0;
    for (int i = 0; i < 4; i++) begin
      b.addr = base + 16'(i);
      b.we   = we;
      b.data = wdata[63-16*i -: 16];
      b.cyc  = k + 1 + i + ((i >= stall_beat) ? stall_len : 0);
      q_beat.push_back(b);
      line = {line[47:0], 16'hA000 + b.addr};
    end
    if (!is_d) m_i_line = line;
    else if (!we) m_d_line = line;
    a.is_d = is_d;
    a.line = is_d ? m_d_line : m_i_line;
    a.cyc  = k + 5 + stall_len;
    q_ack.push_back(a);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q_ack.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("ack_timeout", q_ack.size(), 0);
    chk("beats_left", q_beat.size(), 0);
    q_ack.delete();
    q_beat.delete();
    cycle();
    cycle();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    i_req   = 1'b0;
    d_req   = 1'b0;
    i_drop  = 1'b0;
    d_drop  = 1'b0;
    i_left  = 0;
    d_left  = 0;
    q_beat.delete();
    q_ack.delete();
    m_i_line = '0;
    m_d_line = '0;
    cycle();
    chk("rst_acks", {i_ack, d_ack}, 2'b00);
    chk("rst_strobes", {mem_read, mem_write}, 2'b00);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_i_line", i_line, 64'h0);
    chk("rst_d_line", d_line, 64'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, seen;
    reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_ready = 1'b1;
    apply_reset();

    // I-cache read of an unaligned address
    i_addr = 16'h0013; i_req = 1'b1; i_left = 1;
    push_xfer(1'b0, 1'b0, 16'h0013, 64'h0, cyc, 4, 0);
    drain(40);

    // Simultaneous requests straight after reset: D first, I seven cycles later
    apply_reset();
    d_addr = 16'h0040; d_we = 1'b0; d_req = 1'b1; d_left = 1;
    i_addr = 16'h0105; i_req = 1'b1; i_left = 1;
    push_xfer(1'b1, 1'b0, 16'h0040, 64'h0, cyc, 4, 0);
    push_xfer(1'b0, 1'b0, 16'h0105, 64'h0, cyc + 7, 4, 0);
    drain(60);

    // D write-back; d_line must keep the earlier read line
    d_addr = 16'h0021; d_we = 1'b1; d_wdata = 64'h1111_2222_3333_4444;
    d_req = 1'b1; d_left = 1;
    push_xfer(1'b1, 1'b1, 16'h0021, 64'h1111_2222_3333_4444, cyc, 4, 0);
    drain(40);
    d_we = 1'b0;

    // I read with memory stalling beat 2 for three cycles
    i_addr = 16'h0032; i_req = 1'b1; i_left = 1;
    stall_from = cyc + 3; stall_to = cyc + 6;
    push_xfer(1'b0, 1'b0, 16'h0032, 64'h0, cyc, 2, 3);
    drain(40);

    // Reset during beat 1 of a D read aborts it; a fresh read then completes
    d_addr = 16'h0050; d_req = 1'b1; d_left = 1;
    push_xfer(1'b1, 1'b0, 16'h0050, 64'h0, cyc, 4, 0);
    cycle();
    cycle();
    seen = n_ack_seen;
    apply_reset();
    repeat (8) cycle();
    chk("abort_no_ack", n_ack_seen, seen);
    d_addr = 16'h0058; d_req = 1'b1; d_left = 1;
    push_xfer(1'b1, 1'b0, 16'h0058, 64'h0, cyc, 4, 0);
    drain(40);

    // i_req held through three transfers: acks exactly seven cycles apart
    i_addr = 16'h0080; i_req = 1'b1; i_left = 3;
    k = cyc;
    push_xfer(1'b0, 1'b0, 16'h0080, 64'h0, k, 4, 0);
    push_xfer(1'b0, 1'b0, 16'h0080, 64'h0, k + 7, 4, 0);
    push_xfer(1'b0, 1'b0, 16'h0080, 64'h0, k + 14, 4, 0);
    drain(80);
    repeat (4) cycle();
    chk("final_quiet", {i_ack, d_ack, mem_read, mem_write}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
